// File: rtl/up_counter.sv
`timescale 1ns/1ps
// Up counter with sync clear/load, wrap or saturate at MAX_COUNT, and sticky overflow.
// Outputs are registered, so a change appears one clk edge after its cause. There is no backpressure.
module up_counter #(
  parameter int WIDTH     = 2,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  typedef enum logic {
    RUN       = 1'b0,
    SATURATED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic [1:0]       rst_sync;
  logic             rst_n;

  // Assertion reaches the counter immediately; release is retimed through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      count_out <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_out <= count_nxt;
      tc        <= tc_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_out;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = RUN;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      state_nxt = RUN;
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      case (state)
        RUN: begin
          if (count_out >= MAX_VAL) begin
            tc_nxt  = 1'b1;
            ovf_nxt = 1'b1;
            if (wrap_en) begin
              count_nxt = '0;
            end else begin
              count_nxt = MAX_VAL;
              state_nxt = SATURATED;
            end
          end else begin
            count_nxt = count_out + WIDTH'(1);
          end
        end
        SATURATED: begin
          count_nxt = MAX_VAL;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  assign sat = (state == SATURATED);

endmodule
